// File: rtl/rv32_pkg.sv
// Shared RV32 datapath constants and the MUL/DIV result entry carried
// through the write-port arbiter's buffer.
package rv32_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned REG_COUNT = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } md_entry_t;

endpackage

// File: rtl/md_result_fifo.sv
// Small synchronous FIFO for buffered MUL/DIV results; push is ignored when
// full and pop is ignored when empty.
module md_result_fifo #(
  parameter  int unsigned WIDTH = 37,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between writeback and buffered MUL/DIV
// results, tracks outstanding MUL/DIV destinations and flags head starvation.
module regfile_wr_arbiter
  import rv32_pkg::*;
#(
  parameter int unsigned DATA_W       = rv32_pkg::DATA_W,
  parameter int unsigned ADDR_W       = rv32_pkg::ADDR_W,
  parameter int unsigned BUF_DEPTH    = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WB_VALID,
  input  logic [ADDR_W-1:0] WB_ADDR,
  input  logic [DATA_W-1:0] WB_DATA,
  input  logic              MD_ISSUE_VALID,
  input  logic [ADDR_W-1:0] MD_ISSUE_ADDR,
  input  logic              MD_VALID,
  input  logic [ADDR_W-1:0] MD_ADDR,
  input  logic [DATA_W-1:0] MD_DATA,
  output logic              MD_READY,
  output logic              RF_WRITE,
  output logic [ADDR_W-1:0] RF_INADDRESS,
  output logic [DATA_W-1:0] RF_IN,
  output logic [31:0]       BUSY,
  output logic              STALL_REQ
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 1);

  md_entry_t         push_entry, head_entry;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              push, pop;

  logic              ready_en_q;
  logic              rf_write_q, rf_write_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  logic [31:0]       busy_q, busy_d;
  logic [AGE_W-1:0]  age_q, age_d;
  logic              stall_q, stall_d;

  assign push_entry.addr = MD_ADDR;
  assign push_entry.data = MD_DATA;

  // Ready comes from registered state only; ready_en_q holds it low until
  // the first edge after reset release.
  assign MD_READY = ready_en_q & (fifo_count < CNT_W'(BUF_DEPTH));
  assign push     = MD_VALID & MD_READY;
  assign pop      = ~fifo_empty & ~WB_VALID;

  md_result_fifo #(
    .WIDTH ($bits(md_entry_t)),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RESET),
    .push_i  (push),
    .din_i   (push_entry),
    .pop_i   (pop),
    .dout_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    rf_write_d = 1'b0;
    rf_addr_d  = rf_addr_q;
    rf_data_d  = rf_data_q;
    if (WB_VALID) begin
      rf_write_d = (WB_ADDR != '0);
      rf_addr_d  = WB_ADDR;
      rf_data_d  = WB_DATA;
    end else if (pop) begin
      rf_write_d = (head_entry.addr != '0);
      rf_addr_d  = head_entry.addr;
      rf_data_d  = head_entry.data;
    end
  end

  // Clear before set so a same-cycle reissue of the popped register wins.
  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[head_entry.addr] = 1'b0;
    if (MD_ISSUE_VALID && MD_ISSUE_ADDR != '0) busy_d[MD_ISSUE_ADDR] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    age_d = age_q;
    if (fifo_empty || pop) age_d = '0;
    else if (age_q < AGE_W'(STARVE_LIMIT)) age_d = age_q + 1'b1;
    stall_d = (age_d >= AGE_W'(STARVE_LIMIT));
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ready_en_q <= 1'b0;
      rf_write_q <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
      busy_q     <= '0;
      age_q      <= '0;
      stall_q    <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      rf_write_q <= rf_write_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
      busy_q     <= busy_d;
      age_q      <= age_d;
      stall_q    <= stall_d;
    end
  end

  assign RF_WRITE     = rf_write_q;
  assign RF_INADDRESS = rf_addr_q;
  assign RF_IN        = rf_data_q;
  assign BUSY         = busy_q;
  assign STALL_REQ    = stall_q;

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Write-port arbiter and scoreboard for the 32×32 register file in the RV32IM pipeline. Shares the register file's single write port between the in-order writeback stage and the multi-cycle MUL/DIV unit, buffering MUL/DIV results in a small FIFO. Tracks destination registers with outstanding MUL/DIV results for the hazard unit. Requests a pipeline stall when a buffered result has been starved too long.

## Interface
- DATA_W, 32, data width
- ADDR_W, 5, register address width
- BUF_DEPTH, 2, MUL/DIV result FIFO depth (≥1)
- STARVE_LIMIT, 4, cycles a FIFO head may wait before STALL_REQ
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- WB_VALID  in  1  pipeline writeback valid; never back-pressured
- WB_ADDR  in  ADDR_W  writeback destination
- WB_DATA  in  DATA_W  writeback data
- MD_ISSUE_VALID  in  1  MUL/DIV instruction issued this cycle
- MD_ISSUE_ADDR  in  ADDR_W  its destination register
- MD_VALID  in  1  MUL/DIV result valid
- MD_ADDR  in  ADDR_W  result destination
- MD_DATA  in  DATA_W  result data
- MD_READY  out  1  FIFO can accept; transfer when MD_VALID & MD_READY
- RF_WRITE  out  1  register-file write enable
- RF_INADDRESS  out  ADDR_W  register-file write address
- RF_IN  out  DATA_W  register-file write data
- BUSY  out  32  bit r set while a MUL/DIV result for xr is outstanding
- STALL_REQ  out  1  request pipeline freeze to drain FIFO

## Operation
- Priority each cycle: WB_VALID > FIFO head. WB is never dropped or delayed.
- Selected write is registered onto RF_WRITE/RF_INADDRESS/RF_IN. Unselected cycle: RF_WRITE=0, addr/data hold last values.
- Address 0: a WB or popped entry with addr 0 produces RF_WRITE=0. The slot is still consumed, and the FIFO still pops.
- All MD results enter the FIFO; no bypass. MD_READY = (count < BUF_DEPTH), from registered count only. When full, it stays 0 even in a pop cycle.
- Simultaneous push and pop: count unchanged, ordering preserved.
- Scoreboard:
  - MD_ISSUE_VALID with addr≠0 sets BUSY[addr].
  - Pop of entry addr clears BUSY[addr].
  - Set and clear of the same addr in the same cycle: set wins.
  - BUSY[0] is always 0.
- Starvation:
  - Age counter increments each cycle the FIFO is non-empty and the head is not popped. It saturates at STARVE_LIMIT.
  - STALL_REQ is registered, high while age ≥ STARVE_LIMIT.
  - Age resets to 0 on every pop and when the FIFO is empty. STALL_REQ therefore drops in the cycle after the pop edge.
- Contract violations, flagged by bench assertions; RTL takes no special action:
  - MD_ISSUE to an already-BUSY register.
  - WB to a BUSY register.
  - MD result whose addr is not BUSY.

## Timing
- WB sampled at edge k → RF_WRITE=1 in cycle after k (latency 1).
- MD accepted at edge k → earliest RF_WRITE after edge k+1 (latency 2). Each WB-occupied cycle adds 1.
- BUSY updates visible in the cycle after the issue/pop edge.
- RESET low, asynchronously:
  - RF_WRITE=0, RF_INADDRESS=0, RF_IN=0.
  - BUSY=0, STALL_REQ=0, MD_READY=0.
  - FIFO emptied and age=0.
- Reset mid-operation discards buffered results. MD_READY rises in the first cycle after RESET deasserts.

## Structure
- Shared package rv32_pkg: DATA_W, ADDR_W, REG_COUNT=32, and the MD result entry struct {addr, data}.
- One sub-module, md_result_fifo: parameterised sync FIFO with push/pop/full/empty/count and async active-low reset.
- Arbiter, scoreboard and age counter live in the top module.

## Test plan
- Reset: hold RESET low with WB_VALID=1, MD_VALID=1 → all outputs 0, MD_READY=0. Release → MD_READY=1 next cycle, no RF_WRITE.
- WB only: WB x5=0xDEADBEEF at edge k → RF_WRITE=1, addr 5, data 0xDEADBEEF in cycle after k. WB to x0 → RF_WRITE=0.
- MD path:
  - Issue x7, then result x7=0x12345678 with WB idle.
  - BUSY[7]=1 after issue.
  - RF_WRITE of x7 two cycles after acceptance.
  - BUSY[7]=0 the cycle after.
- Full/back-pressure with BUF_DEPTH=2: two MD results accepted under continuous WB → MD_READY=0. Third MD_VALID held until a pop. Writes occur in FIFO order.
- Starvation with STARVE_LIMIT=4: FIFO non-empty and WB_VALID=1 every cycle → STALL_REQ=1 after 4 waiting cycles. Drop WB_VALID → head written and STALL_REQ=0 the cycle after the pop.
- Collision: same-cycle MD_ISSUE x9 and pop of x9 → BUSY[9]=1. Async reset asserted mid-drain → FIFO contents lost, no further RF_WRITE.
